lm32_sim_exit_monitor: RTL and testbench
========================================

Name: lm32_sim_exit_monitor

Overview:
- Parametrised, synthesizable simulation-termination and post-mortem monitor for the LM32 platform benches.
- Taps CPU pipeline and bus-error signals, and tracks system calls through the M and W stages.
- Detects the exit call, bus errors, pipeline hangs and global timeout, and records the termination cause and exit code.
- Keeps a circular history of the last retired PCs so the bench can dump it before finishing.

Parameters:
- PC_WIDTH, 30: width of word-address PC from core (byte PC = {pc, 2'b00}).
- HIST_DEPTH, 16: retired-PC history entries; power of two, >= 2.
- EXIT_SCALL_NUM, 1: r8 value identifying the exit system call.
- STALL_LIMIT, 1024: consecutive stall_m cycles declaring a hang; 0 disables.
- TIMEOUT_CYCLES, 0: cycles after reset before forced finish; 0 disables.

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- stall_m_i  in  1  core M-stage stall.
- scall_x_i  in  1  scall decoded in X.
- valid_x_i  in  1  X stage valid.
- valid_m_i  in  1  M stage valid.
- valid_w_i  in  1  W stage valid.
- pc_w_i  in  PC_WIDTH  W-stage word PC.
- r8_i  in  32  register file r8 (syscall number).
- r1_i  in  32  register file r1 (exit code).
- i_err_i  in  1  instruction bus error.
- d_err_i  in  1  data bus error.
- hist_idx_i  in  log2(HIST_DEPTH)  history read index; 0 = most recent.
- hist_pc_o  out  32  byte PC at hist_idx_i (combinational read).
- hist_count_o  out  log2(HIST_DEPTH)+1  valid history entries.
- retired_o  out  32  retired-instruction count.
- done_o  out  1  sticky termination flag.
- cause_o  out  3  termination cause: 0 none, 1 exit, 2 ibus, 3 dbus, 4 stall hang, 5 timeout.
- exit_code_o  out  32  r1 captured at exit; 0 for any other cause.

Behaviour:
- Reset: all outputs, counters, history pointer, scall_m and scall_w go to 0. Reset takes priority over every event, including mid-run and after done.
- States:
  - RUN (after reset).
  - DONE (entered when any termination condition holds at a rising edge).
  - DONE is absorbing until rst_i. In DONE, all registers freeze, including history, counters and scall pipe.
- Scall pipe (RUN only), when stall_m_i == 0:
  - scall_m <= scall_x_i & valid_x_i.
  - scall_w <= scall_m & valid_m_i.
  - When stall_m_i == 1, both hold.
- Exit condition: scall_w == 1 and r8_i == EXIT_SCALL_NUM, sampled at the edge. An scall with another r8 value is ignored.
- Exit latency: done_o is high after the 3rd rising edge counting the edge that samples scall_x_i & valid_x_i, with no stalls in between. Each stalled cycle adds one cycle.
- Retirement: valid_w_i & ~stall_m_i.
  - Each retirement writes {pc_w_i, 2'b00} at the write pointer, increments the pointer (wraps mod HIST_DEPTH) and increments retired_o (wraps at 2^32).
  - hist_count_o saturates at HIST_DEPTH.
- History read: entry = buf[(wptr - 1 - hist_idx_i) mod HIST_DEPTH]. Returns 0 when hist_idx_i >= hist_count_o.
- Stall counter:
  - Counts consecutive cycles with stall_m_i high and clears when it is low.
  - Reaching STALL_LIMIT gives cause 4.
  - The counter saturates, with no wrap.
- Timeout counter:
  - Counts cycles in RUN.
  - Reaching TIMEOUT_CYCLES gives cause 5.
  - With the parameter at 0 the counter is still present but never triggers.
- Simultaneous conditions: priority is ibus(2) > dbus(3) > exit(1) > hang(4) > timeout(5). Exactly one cause is latched.
- exit_code_o is loaded from r1_i only when cause 1 is latched.
- A retirement on the same edge as termination is still recorded. A retirement in DONE is not.
- done_o, cause_o and exit_code_o are registered with no combinational path from inputs. hist_pc_o is combinational from hist_idx_i.

Test Plan:
1. Exit call: r8_i=1, r1_i=42, single scall_x_i&valid_x_i pulse, valid_m_i high, no stalls -> done_o rises after 3rd edge; cause_o=1; exit_code_o=42.
2. Non-exit call: same sequence with r8_i=2 -> done_o stays 0 for 100 cycles. Then insert 2 stall cycles between X and M on a real exit -> done_o delayed exactly 2 cycles.
3. History wrap: 20 retirements with pc_w_i = 0x40..0x53 -> hist_count_o=16; retired_o=20; hist_idx_i=0 gives 0x14C; idx 15 gives 0x110.
4. Simultaneous: d_err_i pulse on the same edge the exit condition holds -> cause_o=3, exit_code_o=0. A later i_err_i -> no change (sticky).
5. Hang and timeout, with STALL_LIMIT=8 and TIMEOUT_CYCLES=50:
   - stall_m_i held high -> cause_o=4 after 8 stalled cycles.
   - Separate run with no stalls -> cause_o=5 at cycle 50.
6. Reset mid-operation: after case 1 completes, assert rst_i for 1 cycle -> done_o=0, cause_o=0, exit_code_o=0, hist_count_o=0, retired_o=0. A new exit with r1_i=7 -> exit_code_o=7.

Source files
------------

// File: rtl/lm32_sim_exit_monitor.sv
// rtl/lm32_sim_exit_monitor.sv - LM32 bench termination monitor with retired-PC history
module lm32_sim_exit_monitor #(
    parameter int          PC_WIDTH       = 30,
    parameter int          HIST_DEPTH     = 16,
    parameter logic [31:0] EXIT_SCALL_NUM = 32'd1,
    parameter int          STALL_LIMIT    = 1024,
    parameter int          TIMEOUT_CYCLES = 0,
    localparam int         IDX_W          = $clog2(HIST_DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_m_i,
    input  logic                scall_x_i,
    input  logic                valid_x_i,
    input  logic                valid_m_i,
    input  logic                valid_w_i,
    input  logic [PC_WIDTH-1:0] pc_w_i,
    input  logic [31:0]         r8_i,
    input  logic [31:0]         r1_i,
    input  logic                i_err_i,
    input  logic                d_err_i,
    input  logic [IDX_W-1:0]    hist_idx_i,
    output logic [31:0]         hist_pc_o,
    output logic [IDX_W:0]      hist_count_o,
    output logic [31:0]         retired_o,
    output logic                done_o,
    output logic [2:0]          cause_o,
    output logic [31:0]         exit_code_o
);

    typedef enum logic {ST_RUN, ST_DONE} state_t;

    localparam logic [31:0]    STALL_LIM   = 32'(STALL_LIMIT);
    localparam logic [31:0]    TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
    localparam logic [IDX_W:0] DEPTH       = (IDX_W+1)'(HIST_DEPTH);

    state_t              state_q, state_d;
    logic                scall_m_q, scall_m_d;
    logic                scall_w_q, scall_w_d;
    logic [IDX_W-1:0]    wptr_q, wptr_d;
    logic [IDX_W:0]      count_q, count_d;
    logic [31:0]         retired_q, retired_d;
    logic [31:0]         stall_cnt_q, stall_cnt_d;
    logic [31:0]         tmo_cnt_q, tmo_cnt_d;
    logic [2:0]          cause_q, cause_d;
    logic [31:0]         exit_code_q, exit_code_d;
    logic [31:0]         hist_q [HIST_DEPTH];
    logic [31:0]         hist_d [HIST_DEPTH];

    logic                retire;
    logic [31:0]         stall_next;
    logic [31:0]         tmo_next;
    logic                hit_exit;
    logic                hit_hang;
    logic                hit_tmo;
    logic [PC_WIDTH+1:0] pc_byte;
    logic [IDX_W-1:0]    rd_ptr;

    // Event qualifiers; both counters saturate rather than wrap
    assign retire     = valid_w_i & ~stall_m_i;
    assign stall_next = !stall_m_i ? 32'd0 :
                        (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + 32'd1;
    assign tmo_next   = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + 32'd1;
    assign hit_exit   = scall_w_q && (r8_i == EXIT_SCALL_NUM);
    assign hit_hang   = (STALL_LIMIT != 0) && (stall_next == STALL_LIM);
    assign hit_tmo    = (TIMEOUT_CYCLES != 0) && (tmo_next == TIMEOUT_LIM);
    assign pc_byte    = {pc_w_i, 2'b00};

    // Next-state: everything advances only in RUN; DONE freezes all state
    always_comb begin
        state_d     = state_q;
        scall_m_d   = scall_m_q;
        scall_w_d   = scall_w_q;
        wptr_d      = wptr_q;
        count_d     = count_q;
        retired_d   = retired_q;
        stall_cnt_d = stall_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        cause_d     = cause_q;
        exit_code_d = exit_code_q;
        hist_d      = hist_q;
        if (state_q == ST_RUN) begin
            stall_cnt_d = stall_next;
            tmo_cnt_d   = tmo_next;
            if (!stall_m_i) begin
                scall_m_d = scall_x_i & valid_x_i;
                scall_w_d = scall_m_q & valid_m_i;
            end
            if (retire) begin
                hist_d[wptr_q] = 32'(pc_byte);
                wptr_d         = wptr_q + IDX_W'(1);
                retired_d      = retired_q + 32'd1;
                if (count_q != DEPTH) begin
                    count_d = count_q + (IDX_W+1)'(1);
                end
            end
            if (i_err_i) begin
                state_d = ST_DONE;
                cause_d = 3'd2;
            end else if (d_err_i) begin
                state_d = ST_DONE;
                cause_d = 3'd3;
            end else if (hit_exit) begin
                state_d     = ST_DONE;
                cause_d     = 3'd1;
                exit_code_d = r1_i;
            end else if (hit_hang) begin
                state_d = ST_DONE;
                cause_d = 3'd4;
            end else if (hit_tmo) begin
                state_d = ST_DONE;
                cause_d = 3'd5;
            end
        end
    end

    // State registers; reset wins over every event, including in DONE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            scall_m_q   <= 1'b0;
            scall_w_q   <= 1'b0;
            wptr_q      <= '0;
            count_q     <= '0;
            retired_q   <= '0;
            stall_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            cause_q     <= '0;
            exit_code_q <= '0;
            hist_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            scall_m_q   <= scall_m_d;
            scall_w_q   <= scall_w_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            retired_q   <= retired_d;
            stall_cnt_q <= stall_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            cause_q     <= cause_d;
            exit_code_q <= exit_code_d;
            hist_q      <= hist_d;
        end
    end

    // History read counts back from the newest entry; unfilled slots read as 0
    assign rd_ptr       = wptr_q - IDX_W'(1) - hist_idx_i;
    assign hist_pc_o    = ({1'b0, hist_idx_i} < count_q) ? hist_q[rd_ptr] : 32'd0;
    assign hist_count_o = count_q;
    assign retired_o    = retired_q;
    assign done_o       = (state_q == ST_DONE);
    assign cause_o      = cause_q;
    assign exit_code_o  = exit_code_q;

endmodule

// File: tb/tb_lm32_sim_exit_monitor.sv
// tb/tb_lm32_sim_exit_monitor.sv - scoreboard bench for lm32_sim_exit_monitor
module tb_lm32_sim_exit_monitor;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        stall_m, scall_x, valid_x, valid_m, valid_w;
    logic [29:0] pc_w;
    logic [31:0] r8, r1;
    logic        i_err, d_err;
    logic [3:0]  hist_idx;

    logic [31:0] hist_pc_a, retired_a, code_a, hist_pc_b, retired_b, code_b;
    logic [4:0]  hist_count_a, hist_count_b;
    logic        done_a, done_b;
    logic [2:0]  cause_a, cause_b;

    always #5 clk = ~clk;

    lm32_sim_exit_monitor dut_a (
        .clk_i(clk), .rst_i(rst_a), .stall_m_i(stall_m), .scall_x_i(scall_x),
        .valid_x_i(valid_x), .valid_m_i(valid_m), .valid_w_i(valid_w), .pc_w_i(pc_w),
        .r8_i(r8), .r1_i(r1), .i_err_i(i_err), .d_err_i(d_err), .hist_idx_i(hist_idx),
        .hist_pc_o(hist_pc_a), .hist_count_o(hist_count_a), .retired_o(retired_a),
        .done_o(done_a), .cause_o(cause_a), .exit_code_o(code_a)
    );

    lm32_sim_exit_monitor #(.STALL_LIMIT(8), .TIMEOUT_CYCLES(50)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .stall_m_i(stall_m), .scall_x_i(scall_x),
        .valid_x_i(valid_x), .valid_m_i(valid_m), .valid_w_i(valid_w), .pc_w_i(pc_w),
        .r8_i(r8), .r1_i(r1), .i_err_i(i_err), .d_err_i(d_err), .hist_idx_i(hist_idx),
        .hist_pc_o(hist_pc_b), .hist_count_o(hist_count_b), .retired_o(retired_b),
        .done_o(done_b), .cause_o(cause_b), .exit_code_o(code_b)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    typedef struct {
        string       name;
        logic [2:0]  cause;
        logic [31:0] code;
        int          cyc;
    } ev_t;

    chk_t chk_q[$];
    ev_t  ev_a_q[$];
    ev_t  ev_b_q[$];

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    logic end_req = 1'b0;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] probe(input int sel);
        case (sel)
            0:       return {31'd0, done_a};
            1:       return {29'd0, cause_a};
            2:       return code_a;
            3:       return {27'd0, hist_count_a};
            4:       return retired_a;
            5:       return hist_pc_a;
            6:       return {31'd0, done_b};
            7:       return {29'd0, cause_b};
            8:       return code_b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push_chk(input string n, input int sel, input logic [31:0] e);
        chk_t c;
        c.name = n;
        c.sel  = sel;
        c.exp  = e;
        chk_q.push_back(c);
    endtask

    task automatic expect_ev(input int dut, input string n, input logic [2:0] c,
                             input logic [31:0] code, input int at);
        ev_t e;
        e.name  = n;
        e.cause = c;
        e.code  = code;
        e.cyc   = at;
        if (dut == 0) ev_a_q.push_back(e);
        else          ev_b_q.push_back(e);
    endtask

    // Monitor: drains pending value checks and scores every rising done_o
    always @(negedge clk) begin
        chk_t        c;
        ev_t         e;
        logic [31:0] act;
        while (chk_q.size() > 0) begin
            c   = chk_q.pop_front();
            act = probe(c.sel);
            tests++;
            if (act !== c.exp) begin
                fails++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", c.name, act, c.exp, cyc);
            end
        end
        if (done_a === 1'b1 && prev_a === 1'b0) begin
            tests++;
            if (ev_a_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done_a: cause %0d code 0x%08h at cycle %0d, expected no termination", cause_a, code_a, cyc);
            end else begin
                e = ev_a_q.pop_front();
                if (cause_a !== e.cause || code_a !== e.code || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL %s: cause %0d code 0x%08h cycle %0d, expected cause %0d code 0x%08h cycle %0d", e.name, cause_a, code_a, cyc, e.cause, e.code, e.cyc);
                end
            end
        end
        if (done_b === 1'b1 && prev_b === 1'b0) begin
            tests++;
            if (ev_b_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done_b: cause %0d at cycle %0d, expected no termination", cause_b, cyc);
            end else begin
                e = ev_b_q.pop_front();
                if (cause_b !== e.cause || code_b !== e.code || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL %s: cause %0d code 0x%08h cycle %0d, expected cause %0d code 0x%08h cycle %0d", e.name, cause_b, code_b, cyc, e.cause, e.code, e.cyc);
                end
            end
        end
        prev_a = done_a;
        prev_b = done_b;
        if (end_req) begin
            end_req = 1'b0;
            tests += 2;
            if (ev_a_q.size() != 0) begin
                fails++;
                $display("FAIL pending_done_a: %0d terminations never seen, expected 0", ev_a_q.size());
            end
            if (ev_b_q.size() != 0) begin
                fails++;
                $display("FAIL pending_done_b: %0d terminations never seen, expected 0", ev_b_q.size());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        step(1);
        rst_a = 1'b0;
    endtask

    task automatic issue_scall(input logic [31:0] r8v, input logic [31:0] r1v,
                               input int stalls, input logic expect_exit, input string n);
        r8      = r8v;
        r1      = r1v;
        scall_x = 1'b1;
        valid_x = 1'b1;
        if (expect_exit) expect_ev(0, n, 3'd1, r1v, cyc + 3 + stalls);
        step(1);
        scall_x = 1'b0;
        valid_x = 1'b0;
        if (stalls > 0) begin
            stall_m = 1'b1;
            step(stalls);
            stall_m = 1'b0;
        end
        step(3);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        stall_m = 1'b0; scall_x = 1'b0; valid_x = 1'b0; valid_m = 1'b1; valid_w = 1'b0;
        pc_w = '0; r8 = '0; r1 = '0; i_err = 1'b0; d_err = 1'b0; hist_idx = '0;
        step(2);
        rst_a = 1'b0;
        push_chk("reset_done", 0, 32'd0);
        push_chk("reset_cause", 1, 32'd0);
        push_chk("reset_code", 2, 32'd0);
        push_chk("reset_count", 3, 32'd0);
        push_chk("reset_retired", 4, 32'd0);
        push_chk("reset_hist0", 5, 32'd0);

        // Exit call with a retirement on the terminating edge, then retirements in DONE
        r8 = 32'd1; r1 = 32'd42; scall_x = 1'b1; valid_x = 1'b1;
        expect_ev(0, "exit_42", 3'd1, 32'd42, cyc + 3);
        step(1);
        scall_x = 1'b0; valid_x = 1'b0;
        step(1);
        valid_w = 1'b1; pc_w = 30'h100;
        step(1);
        pc_w = 30'h200; r1 = 32'd99;
        step(3);
        valid_w = 1'b0;
        push_chk("exit_done", 0, 32'd1);
        push_chk("exit_cause", 1, 32'd1);
        push_chk("exit_code_held", 2, 32'd42);
        push_chk("retire_on_term_edge", 4, 32'd1);
        push_chk("count_after_exit", 3, 32'd1);
        push_chk("hist0_after_exit", 5, 32'h400);
        step(1);
        hist_idx = 4'd1;
        push_chk("hist1_beyond_count", 5, 32'd0);
        step(1);
        hist_idx = 4'd0;

        // Reset after done, then a fresh exit
        reset_a();
        push_chk("rst_done", 0, 32'd0);
        push_chk("rst_cause", 1, 32'd0);
        push_chk("rst_code", 2, 32'd0);
        push_chk("rst_count", 3, 32'd0);
        push_chk("rst_retired", 4, 32'd0);
        issue_scall(32'd1, 32'd7, 0, 1'b1, "exit_7");
        push_chk("exit7_code", 2, 32'd7);

        // Non-exit syscall is ignored; stalls between X and M delay exit
        reset_a();
        issue_scall(32'd2, 32'd55, 0, 1'b0, "non_exit");
        step(100);
        push_chk("non_exit_done", 0, 32'd0);
        push_chk("non_exit_cause", 1, 32'd0);
        issue_scall(32'd1, 32'h1234, 2, 1'b1, "exit_stall2");
        push_chk("stall_exit_code", 2, 32'h1234);

        // History wrap with one stalled (non-retiring) slot in the middle
        reset_a();
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                valid_w = 1'b1; stall_m = 1'b1; pc_w = 30'h3FF;
                step(1);
                stall_m = 1'b0;
            end
            valid_w = 1'b1;
            pc_w    = 30'h40 + 30'(i);
            step(1);
        end
        valid_w = 1'b0;
        push_chk("wrap_count", 3, 32'd16);
        push_chk("wrap_retired", 4, 32'd20);
        push_chk("wrap_hist0", 5, 32'h14C);
        step(1);
        hist_idx = 4'd1;
        push_chk("wrap_hist1", 5, 32'h148);
        step(1);
        hist_idx = 4'd15;
        push_chk("wrap_hist15", 5, 32'h110);
        step(1);
        hist_idx = 4'd0;

        // Dbus error beats a simultaneous exit; later ibus error cannot change it
        reset_a();
        r8 = 32'd1; r1 = 32'd42; scall_x = 1'b1; valid_x = 1'b1;
        step(1);
        scall_x = 1'b0; valid_x = 1'b0;
        step(1);
        d_err = 1'b1;
        expect_ev(0, "derr_with_exit", 3'd3, 32'd0, cyc + 1);
        step(1);
        d_err = 1'b0;
        step(2);
        i_err = 1'b1;
        step(1);
        i_err = 1'b0;
        step(1);
        push_chk("sticky_cause", 1, 32'd3);
        push_chk("sticky_code", 2, 32'd0);

        // Ibus beats dbus on the same edge
        reset_a();
        i_err = 1'b1; d_err = 1'b1;
        expect_ev(0, "ibus_over_dbus", 3'd2, 32'd0, cyc + 1);
        step(1);
        i_err = 1'b0; d_err = 1'b0;
        step(1);
        push_chk("ibus_cause", 1, 32'd2);

        // Reset wins over an error on the same edge
        rst_a = 1'b1; d_err = 1'b1;
        step(1);
        rst_a = 1'b0; d_err = 1'b0;
        push_chk("reset_over_err_done", 0, 32'd0);
        push_chk("reset_over_err_cause", 1, 32'd0);

        // Hang: 7 stalls then a break, then 8 consecutive stalls
        rst_b = 1'b0; stall_m = 1'b1;
        step(7);
        stall_m = 1'b0;
        step(1);
        stall_m = 1'b1;
        expect_ev(1, "hang", 3'd4, 32'd0, cyc + 8);
        step(10);
        stall_m = 1'b0;
        push_chk("hang_cause", 7, 32'd4);
        push_chk("hang_code", 8, 32'd0);

        // Timeout at cycle 50 of a stall-free run
        rst_b = 1'b1;
        step(1);
        rst_b = 1'b0;
        expect_ev(1, "timeout", 3'd5, 32'd0, cyc + 50);
        step(49);
        push_chk("timeout_not_yet", 6, 32'd0);
        step(5);
        push_chk("timeout_done", 6, 32'd1);
        push_chk("timeout_cause", 7, 32'd5);

        step(1);
        end_req = 1'b1;
        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
